// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: RAW/load-use interlock, branch flush,
// and a memory-wait FSM that freezes every stage until the MEM access completes.
module pipeline_hazard_ctrl #(
    parameter bit FWD_EN  = 1'b1,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_use_src1,
    input  logic        id_use_src2,
    input  logic        exe_wb_en,
    input  logic        exe_mem_r_en,
    input  logic [3:0]  exe_dest,
    input  logic        mem_wb_en,
    input  logic [3:0]  mem_dest,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        freeze_if,
    output logic        flush_if_id,
    output logic        flush_id_exe,
    output logic        stall_all,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             load_use1, load_use2, any_use1, any_use2;
    logic             m1, m2, hazard, mem_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_d == ST_TIMEOUT)
                mem_timeout <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready)
                    state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q == WAIT_LAST)
                        state_d = ST_TIMEOUT;
                end
            end
            ST_TIMEOUT: state_d = ST_TIMEOUT;
            default:    state_d = ST_RUN;
        endcase
    end

    // With forwarding only a load in EXE cannot be bypassed; without it any pending write interlocks.
    always_comb begin
        load_use1 = exe_wb_en & exe_mem_r_en & (exe_dest == id_src1);
        load_use2 = exe_wb_en & exe_mem_r_en & (exe_dest == id_src2);
        any_use1  = (exe_wb_en & (exe_dest == id_src1)) | (mem_wb_en & (mem_dest == id_src1));
        any_use2  = (exe_wb_en & (exe_dest == id_src2)) | (mem_wb_en & (mem_dest == id_src2));
        m1        = id_use_src1 & (FWD_EN ? load_use1 : any_use1);
        m2        = id_use_src2 & (FWD_EN ? load_use2 : any_use2);
        hazard    = m1 | m2;
    end

    // A memory stall outranks branch and hazard so both are still present once the stall lifts.
    always_comb begin
        mem_stall    = (state_q == ST_TIMEOUT) | (mem_req & ~mem_ready);
        stall_all    = 1'b0;
        freeze_if    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                stall_all = 1'b1;
                freeze_if = 1'b1;
            end else if (branch_taken) begin
                flush_if_id  = 1'b1;
                flush_id_exe = 1'b1;
            end else if (hazard) begin
                freeze_if    = 1'b1;
                flush_id_exe = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall_all || freeze_if)
            stall_cycles <= stall_cycles + 32'd1;
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: one instance with forwarding, one without,
// both with a short timeout so the TIMEOUT path is reachable.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
    logic       id_use_src1 = 0, id_use_src2 = 0, exe_wb_en = 0, exe_mem_r_en = 0;
    logic       mem_wb_en = 0, branch_taken = 0, mem_req = 0, mem_ready = 0;

    logic        fi_f, fii_f, fie_f, sa_f, to_f, fi_n, fii_n, fie_n, sa_n, to_n;
    logic [31:0] sc_f, sc_n;
    logic [1:0]  st_f, st_n;

    // Output bundle order: {stall_all, freeze_if, flush_if_id, flush_id_exe}
    wire [3:0] out_f = {sa_f, fi_f, fii_f, fie_f};
    wire [3:0] out_n = {sa_n, fi_n, fii_n, fie_n};

    int          checks = 0;
    int          errors = 0;
    int unsigned exp_sc_f = 0, exp_sc_n = 0;

    pipeline_hazard_ctrl #(.FWD_EN(1'b1), .TIMEOUT(4), .CNT_W(8)) dut_f (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_if(fi_f), .flush_if_id(fii_f), .flush_id_exe(fie_f), .stall_all(sa_f),
        .mem_timeout(to_f), .stall_cycles(sc_f), .fsm_state(st_f)
    );

    pipeline_hazard_ctrl #(.FWD_EN(1'b0), .TIMEOUT(4), .CNT_W(8)) dut_n (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_if(fi_n), .flush_if_id(fii_n), .flush_id_exe(fie_n), .stall_all(sa_n),
        .mem_timeout(to_n), .stall_cycles(sc_n), .fsm_state(st_n)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

    // drivers
    task automatic drive_id(input logic [3:0] s1, input logic [3:0] s2, input logic u1, input logic u2);
        id_src1 = s1; id_src2 = s2; id_use_src1 = u1; id_use_src2 = u2;
    endtask

    task automatic drive_exe(input logic wb, input logic mr, input logic [3:0] d,
                             input logic mwb, input logic [3:0] md);
        exe_wb_en = wb; exe_mem_r_en = mr; exe_dest = d; mem_wb_en = mwb; mem_dest = md;
    endtask

    task automatic drive_ctl(input logic br, input logic req, input logic rdy);
        branch_taken = br; mem_req = req; mem_ready = rdy;
    endtask

    task automatic tick(input logic [3:0] ef, input logic [3:0] en);
        if (ef[3] | ef[2]) exp_sc_f++;
        if (en[3] | en[2]) exp_sc_n++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_id(4'd3, 4'd3, 1, 1);
        drive_exe(1, 1, 4'd3, 1, 4'd3);
        drive_ctl(1, 1, 0);
        #1;
        checks++; if (out_f !== 4'b0000) begin errors++; $display("FAIL reset_out_f got %b need 0000", out_f); end
        checks++; if (out_n !== 4'b0000) begin errors++; $display("FAIL reset_out_n got %b need 0000", out_n); end
        checks++; if (st_f !== 2'd0 || st_n !== 2'd0) begin errors++; $display("FAIL reset_state got %0d/%0d need 0", st_f, st_n); end
        checks++; if (to_f !== 1'b0 || sc_f !== 32'd0 || sc_n !== 32'd0) begin
            errors++; $display("FAIL reset_counters got to=%b sc=%0d/%0d need 0", to_f, sc_f, sc_n);
        end
        drive_id(0, 0, 0, 0); drive_exe(0, 0, 0, 0, 0); drive_ctl(0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_sc_f = 0; exp_sc_n = 0;
    endtask

    typedef struct {
        logic [3:0] s1, s2; logic u1, u2;
        logic ewb, emr; logic [3:0] ed; logic mwb; logic [3:0] md;
        logic br; logic [3:0] ef, en;
    } hvec_t;

    task automatic run_vec(input string name, input hvec_t v);
        drive_id(v.s1, v.s2, v.u1, v.u2);
        drive_exe(v.ewb, v.emr, v.ed, v.mwb, v.md);
        drive_ctl(v.br, 0, 0);
        #1;
        checks++; if (out_f !== v.ef) begin errors++; $display("FAIL %s_fwd got %b need %b", name, out_f, v.ef); end
        checks++; if (out_n !== v.en) begin errors++; $display("FAIL %s_nofwd got %b need %b", name, out_n, v.en); end
        tick(v.ef, v.en);
    endtask

    task automatic test_hazard();
        hvec_t t[8];
        t[0] = '{4'd3, 4'd0, 1, 0, 1, 1, 4'd3, 0, 4'd0, 0, 4'b0101, 4'b0101}; // load-use on src1
        t[1] = '{4'd3, 4'd0, 1, 0, 1, 0, 4'd3, 0, 4'd0, 0, 4'b0000, 4'b0101}; // ALU result: forwarded
        t[2] = '{4'd3, 4'd0, 0, 0, 1, 1, 4'd3, 0, 4'd0, 0, 4'b0000, 4'b0000}; // src1 not read
        t[3] = '{4'd0, 4'd3, 0, 1, 1, 1, 4'd3, 0, 4'd0, 0, 4'b0101, 4'b0101}; // load-use on src2
        t[4] = '{4'd0, 4'd5, 0, 1, 0, 0, 4'd0, 1, 4'd5, 0, 4'b0000, 4'b0101}; // MEM-stage writer
        t[5] = '{4'd0, 4'd5, 0, 0, 0, 0, 4'd0, 1, 4'd5, 0, 4'b0000, 4'b0000}; // src2 not read
        t[6] = '{4'd3, 4'd0, 1, 0, 0, 1, 4'd3, 0, 4'd0, 0, 4'b0000, 4'b0000}; // no WB_EN
        t[7] = '{4'd3, 4'd3, 1, 0, 1, 1, 4'd4, 1, 4'd4, 0, 4'b0000, 4'b0000}; // dest differs
        for (int i = 0; i < 8; i++) run_vec($sformatf("hazard%0d", i), t[i]);
        checks++; if (sc_f !== exp_sc_f || sc_n !== exp_sc_n) begin
            errors++; $display("FAIL hazard_stall_cycles got %0d/%0d need %0d/%0d", sc_f, sc_n, exp_sc_f, exp_sc_n);
        end
    endtask

    task automatic test_branch();
        hvec_t t[3];
        t[0] = '{4'd3, 4'd0, 1, 0, 1, 1, 4'd3, 0, 4'd0, 1, 4'b0011, 4'b0011}; // branch beats load-use
        t[1] = '{4'd0, 4'd5, 0, 1, 0, 0, 4'd0, 1, 4'd5, 1, 4'b0011, 4'b0011}; // branch beats RAW
        t[2] = '{4'd0, 4'd5, 0, 1, 0, 0, 4'd0, 1, 4'd5, 0, 4'b0000, 4'b0101}; // branch gone
        for (int i = 0; i < 3; i++) run_vec($sformatf("branch%0d", i), t[i]);
        drive_id(0, 0, 0, 0); drive_exe(0, 0, 0, 0, 0);
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 4; i++) begin
            drive_ctl(1, 1, 0);
            #1;
            checks++; if (out_f !== 4'b1100 || out_n !== 4'b1100) begin
                errors++; $display("FAIL memwait_out%0d got %b/%b need 1100", i, out_f, out_n);
            end
            checks++; if (st_f !== ((i == 0) ? 2'd0 : 2'd1)) begin
                errors++; $display("FAIL memwait_state%0d got %0d need %0d", i, st_f, (i == 0) ? 0 : 1);
            end
            tick(4'b1100, 4'b1100);
        end
        drive_ctl(1, 1, 1);
        #1;
        checks++; if (out_f !== 4'b0011 || out_n !== 4'b0011) begin
            errors++; $display("FAIL memwait_ready got %b/%b need 0011", out_f, out_n);
        end
        tick(4'b0011, 4'b0011);
        drive_ctl(0, 0, 0);
        #1;
        checks++; if (st_f !== 2'd0 || st_n !== 2'd0 || out_f !== 4'b0000 || to_f !== 1'b0) begin
            errors++; $display("FAIL memwait_back_run got st=%0d/%0d out=%b to=%b need 0/0 0000 0", st_f, st_n, out_f, to_f);
        end
        checks++; if (sc_f !== exp_sc_f || sc_n !== exp_sc_n) begin
            errors++; $display("FAIL memwait_stall_cycles got %0d/%0d need %0d/%0d", sc_f, sc_n, exp_sc_f, exp_sc_n);
        end
        tick(4'b0000, 4'b0000);
        drive_ctl(0, 1, 1);
        #1;
        checks++; if (out_f !== 4'b0000) begin errors++; $display("FAIL zero_latency got %b need 0000", out_f); end
        tick(4'b0000, 4'b0000);
        drive_ctl(0, 0, 1);
        #1;
        checks++; if (st_f !== 2'd0 || out_f !== 4'b0000) begin
            errors++; $display("FAIL ready_no_req got st=%0d out=%b need 0 0000", st_f, out_f);
        end
        tick(4'b0000, 4'b0000);
        drive_ctl(0, 0, 0);
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 5; i++) begin
            drive_ctl(0, 1, 0);
            #1;
            checks++; if (out_f !== 4'b1100 || to_f !== 1'b0 || st_f !== ((i == 0) ? 2'd0 : 2'd1)) begin
                errors++; $display("FAIL timeout_wait%0d got out=%b to=%b st=%0d need 1100 0 %0d",
                                   i, out_f, to_f, st_f, (i == 0) ? 0 : 1);
            end
            tick(4'b1100, 4'b1100);
        end
        #1;
        checks++; if (st_f !== 2'd2 || st_n !== 2'd2 || to_f !== 1'b1 || to_n !== 1'b1) begin
            errors++; $display("FAIL timeout_enter got st=%0d/%0d to=%b/%b need 2/2 1/1", st_f, st_n, to_f, to_n);
        end
        tick(4'b1100, 4'b1100);
        drive_ctl(1, 0, 0);
        #1;
        checks++; if (out_f !== 4'b1100 || out_n !== 4'b1100 || to_f !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky got %b/%b to=%b need 1100 1", out_f, out_n, to_f);
        end
        tick(4'b1100, 4'b1100);
        drive_ctl(0, 1, 1);
        #1;
        checks++; if (out_f !== 4'b1100 || st_f !== 2'd2) begin
            errors++; $display("FAIL timeout_ignores_ready got %b st=%0d need 1100 2", out_f, st_f);
        end
        checks++; if (sc_f !== exp_sc_f || sc_n !== exp_sc_n) begin
            errors++; $display("FAIL timeout_stall_cycles got %0d/%0d need %0d/%0d", sc_f, sc_n, exp_sc_f, exp_sc_n);
        end
        rst = 1'b1;
        #1;
        checks++; if (out_f !== 4'b0000 || st_f !== 2'd0 || to_f !== 1'b0 || sc_f !== 32'd0) begin
            errors++; $display("FAIL timeout_reset got out=%b st=%0d to=%b sc=%0d need 0000 0 0 0", out_f, st_f, to_f, sc_f);
        end
        @(negedge clk);
        drive_ctl(0, 0, 0);
        rst = 1'b0;
        exp_sc_f = 0; exp_sc_n = 0;
        tick(4'b0000, 4'b0000);
    endtask

    task automatic test_rst_mid_wait();
        drive_ctl(1, 1, 0);
        tick(4'b1100, 4'b1100);
        #1;
        checks++; if (st_f !== 2'd1 || out_f !== 4'b1100) begin
            errors++; $display("FAIL rstmid_pre got st=%0d out=%b need 1 1100", st_f, out_f);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_f !== 4'b0000 || out_n !== 4'b0000 || st_f !== 2'd0 || st_n !== 2'd0) begin
            errors++; $display("FAIL rstmid_out got %b/%b st=%0d/%0d need 0000 0", out_f, out_n, st_f, st_n);
        end
        checks++; if (sc_f !== 32'd0 || sc_n !== 32'd0 || to_f !== 1'b0) begin
            errors++; $display("FAIL rstmid_counters got sc=%0d/%0d to=%b need 0 0", sc_f, sc_n, to_f);
        end
        @(negedge clk);
        drive_ctl(0, 0, 0);
        rst = 1'b0;
        exp_sc_f = 0; exp_sc_n = 0;
        tick(4'b0000, 4'b0000);
        checks++; if (st_f !== 2'd0 || sc_f !== 32'd0 || out_f !== 4'b0000) begin
            errors++; $display("FAIL rstmid_after got st=%0d sc=%0d out=%b need 0 0 0000", st_f, sc_f, out_f);
        end
    endtask

    initial begin
        test_reset();
        test_hazard();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_rst_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
